// File: rtl/board_pkg.sv
// Shared constants, FSM encoding and small helpers for the two-row digit board.
package board_pkg;

  localparam int NUM_CELLS = 10;
  localparam int ROW_LEN = 5;
  localparam int CELL_W = 4;
  localparam logic [3:0] NO_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RD,
    WB
  } state_t;

  // 0 columns makes no sense on the board, so it behaves as 1; anything past a full row as 5.
  function automatic logic [2:0] clamp_num(input logic [2:0] raw);
    if (raw == 3'd0) return 3'd1;
    if (raw > 3'(ROW_LEN)) return 3'(ROW_LEN);
    return raw;
  endfunction

  function automatic logic [2:0] cell_col(input logic [3:0] idx);
    logic [3:0] col;
    col = (idx >= 4'(ROW_LEN)) ? idx - 4'(ROW_LEN) : idx;
    return col[2:0];
  endfunction

endpackage

// File: rtl/merge_ctrl_if.sv
// Pulse inputs and board/selection status between the button front end and the board display.
interface merge_ctrl_if;
  import board_pkg::*;

  logic                          load_valid;
  logic [NUM_CELLS*CELL_W-1:0]   load_data;
  logic [2:0]                    num;
  logic [3:0]                    dir;
  logic                          btn_ok;
  logic [NUM_CELLS*CELL_W-1:0]   board;
  logic [3:0]                    cursor;
  logic [3:0]                    sel_idx;
  logic                          sel_valid;
  logic                          busy;
  logic                          done;
  logic [7:0]                    merge_count;

  modport master (
    output load_valid, load_data, num, dir, btn_ok,
    input  board, cursor, sel_idx, sel_valid, busy, done, merge_count
  );

  modport slave (
    input  load_valid, load_data, num, dir, btn_ok,
    output board, cursor, sel_idx, sel_valid, busy, done, merge_count
  );

endinterface

// File: rtl/mod10_add.sv
// Combinational modular adder shared by every merge; the 5-bit sum covers 15+15.
module mod10_add
  import board_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic [CELL_W-1:0] a,
  input  logic [CELL_W-1:0] b,
  output logic [CELL_W-1:0] y
);

  logic [CELL_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign y   = CELL_W'(sum % (CELL_W + 1)'(MODULUS));

endmodule

// File: rtl/merge_ctrl.sv
// Board/cursor/selection sequencer: pick two cells, merge the second into the first
// through the shared adder in an RD/WB sequence with busy/done handshake.
module merge_ctrl
  import board_pkg::state_t, board_pkg::IDLE, board_pkg::ARMED, board_pkg::RD, board_pkg::WB,
         board_pkg::NO_SEL, board_pkg::NUM_CELLS, board_pkg::clamp_num, board_pkg::cell_col;
#(
  parameter int CELL_W  = 4,
  parameter int ROW_LEN = 5,
  parameter int MODULUS = 10
) (
  input logic         clk,
  input logic         rst,
  merge_ctrl_if.slave bus
);

  state_t                           state_reg, state_next;
  logic [NUM_CELLS-1:0][CELL_W-1:0] board_reg, board_next;
  logic [3:0]                       cursor_reg, cursor_next;
  logic [3:0]                       sel_reg, sel_next;
  logic [CELL_W-1:0]                op_a_reg, op_a_next;
  logic [CELL_W-1:0]                op_b_reg, op_b_next;
  logic [7:0]                       count_reg, count_next;
  logic                             done_reg, done_next;
  logic [CELL_W-1:0]                sum;
  logic [2:0]                       n;
  logic                             out_of_range;

  // Up/down toggle the row; left/right walk the valid cells as one linear ring of 2n.
  function automatic logic [3:0] cursor_step(input logic [3:0] cur, input logic [3:0] d,
                                             input logic [2:0] cols);
    logic       row;
    logic [3:0] col, pos, total, nxt;
    row   = cur >= 4'(ROW_LEN);
    col   = row ? cur - 4'(ROW_LEN) : cur;
    pos   = row ? col + {1'b0, cols} : col;
    total = {cols, 1'b0};
    if (d[0] || d[1]) return row ? col : col + 4'(ROW_LEN);
    if (d[2]) nxt = (pos == 4'd0) ? total - 4'd1 : pos - 4'd1;
    else      nxt = (pos == total - 4'd1) ? 4'd0 : pos + 4'd1;
    return (nxt >= {1'b0, cols}) ? nxt - {1'b0, cols} + 4'(ROW_LEN) : nxt;
  endfunction

  mod10_add #(.MODULUS(MODULUS)) u_add (
    .a(op_a_reg),
    .b(op_b_reg),
    .y(sum)
  );

  assign n = clamp_num(bus.num);
  assign out_of_range = (cell_col(cursor_reg) >= n) ||
                        ((sel_reg != NO_SEL) && (cell_col(sel_reg) >= n));

  always_comb begin
    state_next  = state_reg;
    board_next  = board_reg;
    cursor_next = cursor_reg;
    sel_next    = sel_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    count_next  = count_reg;
    done_next   = 1'b0;
    if (bus.load_valid) begin
      board_next  = bus.load_data;
      cursor_next = 4'd0;
      sel_next    = NO_SEL;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE, ARMED: begin
          // A shrunken row invalidates the cursor or pick before any new input is honoured.
          if (out_of_range) begin
            cursor_next = 4'd0;
            sel_next    = NO_SEL;
            state_next  = IDLE;
          end else if (bus.btn_ok) begin
            if (state_reg == IDLE) begin
              sel_next   = cursor_reg;
              state_next = ARMED;
            end else if (cursor_reg == sel_reg) begin
              sel_next   = NO_SEL;
              state_next = IDLE;
            end else begin
              op_a_next  = board_reg[sel_reg];
              op_b_next  = board_reg[cursor_reg];
              state_next = RD;
            end
          end else if (|bus.dir) begin
            cursor_next = cursor_step(cursor_reg, bus.dir, n);
          end
        end
        RD: state_next = WB;
        WB: begin
          board_next[sel_reg] = sum;
          done_next           = 1'b1;
          if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
          sel_next            = NO_SEL;
          state_next          = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      board_reg  <= '0;
      cursor_reg <= 4'd0;
      sel_reg    <= NO_SEL;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      count_reg  <= 8'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      board_reg  <= board_next;
      cursor_reg <= cursor_next;
      sel_reg    <= sel_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      count_reg  <= count_next;
      done_reg   <= done_next;
    end
  end

  assign bus.board       = board_reg;
  assign bus.cursor      = cursor_reg;
  assign bus.sel_idx     = sel_reg;
  assign bus.sel_valid   = (sel_reg != NO_SEL);
  assign bus.busy        = (state_reg == RD) || (state_reg == WB);
  assign bus.done        = done_reg;
  assign bus.merge_count = count_reg;

endmodule

// File: tb/tb_merge_ctrl.sv
// Self-checking bench for merge_ctrl: merge vector table with a writeback scoreboard,
// plus hand-written cursor, cancel, abort, num-shrink, saturation and async-reset sequences.
module tb_merge_ctrl;

  typedef struct {
    int         idx;
    logic [3:0] val;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
  } vec_t;

  localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  merge_ctrl_if bus ();

  merge_ctrl #(.CELL_W(4), .ROW_LEN(5), .MODULUS(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [3:0] cell_of(input int k);
    return bus.board[k*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_dir(input logic [3:0] d);
    bus.dir = d;
    tick();
    bus.dir = 4'd0;
  endtask

  task automatic pulse_ok();
    bus.btn_ok = 1'b1;
    tick();
    bus.btn_ok = 1'b0;
  endtask

  task automatic do_load(input logic [39:0] d, input logic [2:0] cols);
    bus.load_data  = d;
    bus.num        = cols;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Confirms with the cursor on the second cell; returns on the done cycle.
  task automatic confirm_merge(input int idx, input logic [3:0] val, input string tag);
    int   busy_cycles;
    bit   seen;
    exp_t e;
    busy_cycles = 0;
    seen = 1'b0;
    e.idx = idx;
    e.val = val;
    sb_q.push_back(e);
    bus.btn_ok = 1'b1;
    tick();
    bus.btn_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      tick();
    end
    check({tag, "_done"}, 64'(seen), 64'(1));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(2));
    check({tag, "_busy_low_at_done"}, 64'(bus.busy), 64'(0));
    if (exp_count < 255) exp_count++;
    e = sb_q.pop_front();
    check({tag, "_cell"}, 64'(cell_of(e.idx)), 64'(e.val));
    check({tag, "_count"}, 64'(bus.merge_count), 64'(exp_count));
    check({tag, "_sel_cleared"}, 64'(bus.sel_valid), 64'(0));
  endtask

  initial begin
    logic [39:0] d;
    logic [39:0] d2;
    bit          done_seen;

    vecs[0] = '{4'd7, 4'd5, 4'd2};
    vecs[1] = '{4'd15, 4'd15, 4'd0};
    vecs[2] = '{4'd9, 4'd9, 4'd8};
    vecs[3] = '{4'd3, 4'd4, 4'd7};
    vecs[4] = '{4'd0, 4'd0, 4'd0};
    vecs[5] = '{4'd9, 4'd1, 4'd0};
    vecs[6] = '{4'd8, 4'd15, 4'd3};

    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.num        = 3'd5;
    bus.dir        = 4'd0;
    bus.btn_ok     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_board", 64'(bus.board), 64'(0));
    check("rst_cursor", 64'(bus.cursor), 64'(0));
    check("rst_sel_idx", 64'(bus.sel_idx), 64'hF);
    check("rst_sel_valid", 64'(bus.sel_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_count", 64'(bus.merge_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Cell 0 = 7, cell 6 = 5; pick 0, down, right, confirm.
    d = '0;
    d[3:0] = 4'd7;
    d[27:24] = 4'd5;
    do_load(d, 3'd5);
    pulse_ok();
    check("pick0_sel_idx", 64'(bus.sel_idx), 64'(0));
    check("pick0_sel_valid", 64'(bus.sel_valid), 64'(1));
    pulse_dir(DOWN);
    check("down_cursor", 64'(bus.cursor), 64'(5));
    pulse_dir(RIGHT);
    check("right_cursor", 64'(bus.cursor), 64'(6));
    confirm_merge(0, 4'd2, "m7p5");
    check("m7p5_cell6", 64'(cell_of(6)), 64'(5));
    pulse_ok();
    check("pick_on_done_cycle", 64'(bus.sel_idx), 64'(6));

    // Cursor walk with num = 3.
    do_load('0, 3'd3);
    pulse_dir(RIGHT);
    pulse_dir(RIGHT);
    check("n3_cursor2", 64'(bus.cursor), 64'(2));
    pulse_dir(RIGHT);
    check("n3_right_wrap_row", 64'(bus.cursor), 64'(5));
    pulse_dir(LEFT);
    check("n3_left_back", 64'(bus.cursor), 64'(2));
    pulse_dir(LEFT);
    pulse_dir(LEFT);
    pulse_dir(LEFT);
    check("n3_left_wrap", 64'(bus.cursor), 64'(7));
    pulse_dir(UP);
    check("n3_up", 64'(bus.cursor), 64'(2));

    // Pick cell 4 then confirm on it again: cancel.
    d = 40'h98_7654_3210;
    do_load(d, 3'd5);
    repeat (4) pulse_dir(RIGHT);
    pulse_ok();
    check("cancel_pick_idx", 64'(bus.sel_idx), 64'(4));
    pulse_ok();
    check("cancel_sel_valid", 64'(bus.sel_valid), 64'(0));
    check("cancel_sel_idx", 64'(bus.sel_idx), 64'hF);
    check("cancel_done", 64'(bus.done), 64'(0));
    check("cancel_busy", 64'(bus.busy), 64'(0));
    tick();
    check("cancel_board", 64'(bus.board), 64'(d));

    // Merge vector table: cell0 <- cell0 + cell1.
    foreach (vecs[i]) begin
      d = '0;
      d[3:0] = vecs[i].a;
      d[7:4] = vecs[i].b;
      do_load(d, 3'd5);
      pulse_ok();
      pulse_dir(RIGHT);
      confirm_merge(0, vecs[i].sum, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_cell1", i), 64'(cell_of(1)), 64'(vecs[i].b));
    end

    // Load during RD aborts the merge.
    d  = 40'h00_0000_0033;
    d2 = 40'h12_3456_7890;
    do_load(d, 3'd5);
    pulse_ok();
    pulse_dir(RIGHT);
    bus.btn_ok = 1'b1;
    tick();
    bus.btn_ok = 1'b0;
    check("abort_busy_in_rd", 64'(bus.busy), 64'(1));
    bus.load_data  = d2;
    bus.load_valid = 1'b1;
    bus.btn_ok     = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.btn_ok     = 1'b0;
    check("abort_board", 64'(bus.board), 64'(d2));
    check("abort_cursor", 64'(bus.cursor), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_sel_valid", 64'(bus.sel_valid), 64'(0));
    done_seen = bus.done;
    repeat (3) begin
      tick();
      done_seen = done_seen | bus.done;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    check("abort_board_kept", 64'(bus.board), 64'(d2));
    check("abort_count_kept", 64'(bus.merge_count), 64'(exp_count));

    // All direction bits at once: up only. btn_ok with dir: pick without moving.
    pulse_dir(4'b1111);
    check("dir_all_up_only", 64'(bus.cursor), 64'(5));
    bus.dir = RIGHT;
    pulse_ok();
    bus.dir = 4'd0;
    check("ok_dir_cursor", 64'(bus.cursor), 64'(5));
    check("ok_dir_sel", 64'(bus.sel_idx), 64'(5));

    // Shrinking num pushes the cursor and pick back to a valid state.
    do_load('0, 3'd5);
    repeat (4) pulse_dir(RIGHT);
    check("shrink_cursor4", 64'(bus.cursor), 64'(4));
    pulse_ok();
    bus.num = 3'd2;
    tick();
    check("shrink_cursor", 64'(bus.cursor), 64'(0));
    check("shrink_sel_idx", 64'(bus.sel_idx), 64'hF);
    check("shrink_sel_valid", 64'(bus.sel_valid), 64'(0));
    pulse_ok();
    check("shrink_then_pick", 64'(bus.sel_valid), 64'(1));
    pulse_ok();
    check("shrink_then_cancel", 64'(bus.sel_valid), 64'(0));

    // Saturation of merge_count.
    do_load('0, 3'd5);
    for (int i = 0; i < 260; i++) begin
      pulse_ok();
      pulse_dir((i % 2 == 0) ? RIGHT : LEFT);
      pulse_ok();
      tick();
      tick();
      if (exp_count < 255) exp_count++;
    end
    check("count_saturated", 64'(bus.merge_count), 64'(255));
    check("count_model", 64'(bus.merge_count), 64'(exp_count));

    // Reset mid-merge takes effect without a clock edge.
    do_load(40'h00_0000_0055, 3'd5);
    pulse_ok();
    pulse_dir(RIGHT);
    bus.btn_ok = 1'b1;
    tick();
    bus.btn_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_board", 64'(bus.board), 64'(0));
    check("async_rst_count", 64'(bus.merge_count), 64'(0));
    check("async_rst_sel", 64'(bus.sel_idx), 64'hF);
    check("async_rst_cursor", 64'(bus.cursor), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/merge_ctrl.md
# merge_ctrl

Sequencer for the two-row digit board: owns the 10-cell board register, the cursor, and the two-pick selection. It runs each merge through a shared mod-10 adder in a fixed read/write sequence. It sits between the debounced button/direction pulses and the board display logic, and it supersedes ad-hoc per-cycle add logic with an explicit FSM and a busy/done handshake.

## Interface
- `CELL_W`, 4: bits per cell.
- `ROW_LEN`, 5: maximum columns per row (2 rows, 10 cells).
- `MODULUS`, 10: merge result modulus.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_valid`  in  1  single-cycle pulse; load `load_data` into the board.
- `load_data`  in  40  new board; cell k is `[4k+3:4k]`.
- `num`  in  3  active columns per row; 0 is treated as 1, values above 5 as 5.
- `dir`  in  4  single-cycle move pulses: [0] up, [1] down, [2] left, [3] right.
- `btn_ok`  in  1  single-cycle confirm pulse.
- `board`  out  40  current cell values.
- `cursor`  out  4  cursor cell index, 0–9.
- `sel_idx`  out  4  first-picked cell, or 4'hF when there is none.
- `sel_valid`  out  1  a first pick is held.
- `busy`  out  1  merge in progress.
- `done`  out  1  one-cycle pulse when a merge writes back.
- `merge_count`  out  8  completed merges, saturating at 255.

## Operation
- Cell index is row*5 + col. A cell is valid iff col < n, where n is the clamped `num`.
- FSM states: IDLE, ARMED, RD, WB.
- IDLE: `btn_ok` latches `sel_idx` = `cursor`, sets `sel_valid`, and moves to ARMED.
- ARMED, `btn_ok` with `cursor` == `sel_idx`: cancel the pick (`sel_idx` = F, `sel_valid` = 0) and return to IDLE.
- ARMED, `btn_ok` with any other cursor: move to RD. The adder operands are latched as A = cell[`sel_idx`] and B = cell[`cursor`].
- RD lasts 1 cycle, then WB.
- WB: cell[`sel_idx`] ← (A+B) mod 10, using a 5-bit unsigned sum (max 15+15=30). `done` pulses. `merge_count` increments. Selection clears. FSM returns to IDLE. The second cell is unchanged.
- Cursor moves only in IDLE/ARMED. When several pulses arrive together, priority is up > down > left > right; only one is applied.
  - Up/down: toggle row, keep column.
  - Left/right: step through valid cells in linear order (row0 col0..n-1, then row1 col0..n-1), wrapping at both ends.
- When `btn_ok` and `dir` pulse in the same cycle, `btn_ok` wins and `dir` is dropped.
- `dir` and `btn_ok` are ignored in RD/WB.
- `load_valid` has the highest priority in any state:
  - writes the board;
  - sets `cursor` = 0 and clears the selection;
  - forces IDLE, aborting any in-flight merge with no write and no `done`.
- `num` changes: if the cursor's column or `sel_idx`'s column is ≥ the new n, then on the next edge the cursor goes to 0 and the selection clears (FSM to IDLE if it was ARMED). This check is deferred while busy and applied on return to IDLE.

## Timing
- Reset values:
  - `board` = 0, `cursor` = 0, `sel_idx` = 4'hF;
  - `sel_valid` = 0, `busy` = 0, `done` = 0, `merge_count` = 0;
  - FSM = IDLE.
- Moves and picks are visible on outputs the cycle after the pulse edge.
- Merge latency: confirm edge → RD (busy=1) → WB (busy=1). On the next edge `board` is updated, `done` = 1 for one cycle, and `busy` = 0. That is 2 busy cycles and 3 edges from confirm to new board.
- A `btn_ok` during the `done` cycle is accepted as a new first pick.
- `load_valid` and `btn_ok` in the same cycle: load wins and `btn_ok` is dropped.
- Reset asserted mid-merge: all outputs return immediately (asynchronously) to reset values.

## Structure
- `board_pkg` contains:
  - `NUM_CELLS`=10, `ROW_LEN`=5, `CELL_W`=4, `NO_SEL`=4'hF;
  - the state encoding (IDLE, ARMED, RD, WB);
  - a `clamp_num` function.
- Sub-module `mod10_add`: combinational; two 4-bit unsigned operands in, 4-bit (a+b) mod `MODULUS` out. Instantiated once and shared by every merge.
- The cursor-step logic is a function in `merge_ctrl`.

## Test plan
- Reset, then load 0x0000000000 with cells 0=7 and 6=5, num=5. Pick cell 0, move down and right (cursor 6), confirm. Expect `busy` for 2 cycles, then cell0=2, cell6=5, `done` pulse, `merge_count`=1.
- num=3, cursor 2, right → cursor 5. Then left → cursor 2. From cell 0, left → cursor 7 (wrap). From 7, up → cursor 2.
- Pick cell 4, confirm on cell 4 again → `sel_valid`=0, `sel_idx`=F, board unchanged, no `done`.
- Cells 15+15 (load 0xF in cells 0 and 1), merge → cell0=0 (30 mod 10). Then 9+9 → 8.
- `load_valid` during RD → no writeback, no `done`, board = `load_data`, cursor 0. Also: `dir` = 4'b1111 in IDLE applies up only; `btn_ok` with `dir` picks without moving.
- Cursor at 4, num drops to 2 → cursor 0, selection cleared. Also: 256 merges → `merge_count` holds 255.
